// File: rtl/vram_port_arbiter.sv
// Shares BRAM port A between a clear engine, one writer and one reader; grants are registered (1-cycle latency).
// Requests are held until acked; a clear blocks all grants; reads return READ_LAT cycles after rd_ack.
module vram_port_arbiter #(
  parameter int                ADDR_W    = 11,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 2048,
  parameter int                READ_LAT  = 2,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        wr_strb,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_start,
  output logic              init_busy,
  output logic              bram_ena,
  output logic [3:0]        bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  input  logic [DATA_W-1:0] bram_douta
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_addr, clr_addr_nxt;
  logic                rr_last_rd, rr_nxt;
  logic                busy_q, busy_nxt;
  logic [READ_LAT-1:0] rd_pipe;

  logic                ena_nxt;
  logic [3:0]          wea_nxt;
  logic [ADDR_W-1:0]   addra_nxt;
  logic [DATA_W-1:0]   dina_nxt;
  logic                wr_ack_nxt, rd_ack_nxt;
  logic                wr_elig, rd_elig;
  logic                grant_wr, grant_rd;

  // A requester acked this cycle may not be granted again at this edge.
  assign wr_elig = wr_req & ~wr_ack;
  assign rd_elig = rd_req & ~rd_ack;

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    rr_nxt       = rr_last_rd;
    busy_nxt     = 1'b0;
    ena_nxt      = 1'b0;
    wea_nxt      = 4'h0;
    addra_nxt    = bram_addra;
    dina_nxt     = bram_dina;
    wr_ack_nxt   = 1'b0;
    rd_ack_nxt   = 1'b0;
    grant_wr     = 1'b0;
    grant_rd     = 1'b0;

    case (state)
      CLEAR: begin
        busy_nxt  = 1'b1;
        ena_nxt   = 1'b1;
        wea_nxt   = 4'hF;
        addra_nxt = clr_addr;
        dina_nxt  = CLEAR_VAL;
        if (clr_addr == LAST_ADDR) begin
          state_nxt    = RUN;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + ADDR_W'(1);
        end
      end

      RUN: begin
        if (clr_start) begin
          // The edge taking the clear issues no grant, so init_busy leads the first clear write.
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
          busy_nxt     = 1'b1;
        end else begin
          grant_wr = wr_elig & (~rd_elig | rr_last_rd);
          grant_rd = rd_elig & ~grant_wr;
          if (grant_wr) begin
            ena_nxt    = 1'b1;
            wea_nxt    = wr_strb;
            addra_nxt  = wr_addr;
            dina_nxt   = wr_data;
            wr_ack_nxt = 1'b1;
            rr_nxt     = 1'b0;
          end else if (grant_rd) begin
            ena_nxt    = 1'b1;
            wea_nxt    = 4'h0;
            addra_nxt  = rd_addr;
            dina_nxt   = '0;
            rd_ack_nxt = 1'b1;
            rr_nxt     = 1'b1;
          end
        end
      end

      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      rr_last_rd <= 1'b1;
      busy_q     <= 1'b1;
      bram_ena   <= 1'b0;
      bram_wea   <= 4'h0;
      bram_addra <= '0;
      bram_dina  <= '0;
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_addr   <= clr_addr_nxt;
      rr_last_rd <= rr_nxt;
      busy_q     <= busy_nxt;
      bram_ena   <= ena_nxt;
      bram_wea   <= wea_nxt;
      bram_addra <= addra_nxt;
      bram_dina  <= dina_nxt;
      wr_ack     <= wr_ack_nxt;
      rd_ack     <= rd_ack_nxt;
    end
  end

  // Bit i is set i+1 cycles after a rd_ack cycle; clears do not flush it, reset does.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | READ_LAT'(rd_ack);
    end
  end

  assign rd_valid  = rd_pipe[READ_LAT-1] & ~reset;
  assign rd_data   = rd_valid ? bram_douta : '0;
  assign init_busy = reset | busy_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a 2-cycle BRAM model and a read-data scoreboard.
module tb_vram_port_arbiter;

  localparam int          AW    = 11;
  localparam int          DW    = 32;
  localparam int          DEPTH = 2048;
  localparam int          RL    = 2;
  localparam logic [31:0] CLR_V = 32'h0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0]    wr_strb = 4'h0;
  logic          wr_ack;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          clr_start = 1'b0;
  logic          init_busy;
  logic          bram_ena;
  logic [3:0]    bram_wea;
  logic [AW-1:0] bram_addra;
  logic [DW-1:0] bram_dina;
  logic [DW-1:0] bram_douta;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  vram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LAT(RL), .CLEAR_VAL(CLR_V)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_start(clr_start), .init_busy(init_busy),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
    .bram_dina(bram_dina), .bram_douta(bram_douta)
  );

  // Byte-write BRAM, read-first, two-stage output register.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] d1;
  always @(posedge clk) begin
    if (bram_ena) begin
      d1 <= mem[bram_addra];
      for (int b = 0; b < 4; b++)
        if (bram_wea[b]) mem[bram_addra][b*8 +: 8] <= bram_dina[b*8 +: 8];
    end
    bram_douta <= d1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rd_valid pops one expected word and must follow an rd_ack by 2 cycles.
  logic ack_d1 = 1'b0, ack_d2 = 1'b0;
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      chk("rd_valid_timing", ack_d2, 1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_valid_unexpected actual rd_data=%0h required no rd_valid", rd_data);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
    end else begin
      chk("rd_data_idle", rd_data, 0);
    end
    ack_d2 = ack_d1;
    ack_d1 = rd_ack;
  end

  task automatic do_clear(input int lead, input string name);
    int bad = 0;
    repeat (lead) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) @(negedge clk);
      if (!(bram_ena === 1'b1 && bram_wea === 4'hF && bram_addra === AW'(i) &&
            bram_dina === CLR_V && init_busy === 1'b1 && wr_ack === 1'b0 && rd_ack === 1'b0)) begin
        if (bad == 0)
          $display("FAIL %s at word %0d actual ena=%b wea=%h addra=%0d dina=%h busy=%b acks=%b%b required ena=1 wea=f addra=%0d dina=%h busy=1 acks=00",
                   name, i, bram_ena, bram_wea, bram_addra, bram_dina, init_busy, wr_ack, rd_ack, i, CLR_V);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    @(negedge clk);
    chk({name, "_busy_end"}, init_busy, 0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input string name, output int lat);
    lat = 0;
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    do begin @(negedge clk); lat++; end while (wr_ack !== 1'b1 && lat < 20);
    chk({name, "_ack"}, wr_ack, 1);
    chk({name, "_port"}, {bram_ena, bram_wea, bram_addra, bram_dina}, {1'b1, s, a, d});
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [31:0] expd, input bit push,
                         input string name, output int lat);
    lat = 0;
    rd_req = 1'b1; rd_addr = a;
    do begin @(negedge clk); lat++; end while (rd_ack !== 1'b1 && lat < 20);
    chk({name, "_ack"}, rd_ack, 1);
    chk({name, "_port"}, {bram_ena, bram_wea, bram_addra, bram_dina}, {1'b1, 4'h0, a, 32'h0});
    if (push) exp_q.push_back(expd);
    rd_req = 1'b0;
  endtask

  initial begin
    int lat;

    repeat (3) @(negedge clk);
    chk("reset_port", {bram_ena, bram_wea, bram_addra, bram_dina}, 0);
    chk("reset_acks_valid", {wr_ack, rd_ack, rd_valid}, 0);
    chk("reset_busy", init_busy, 1);
    reset = 1'b0;
    do_clear(1, "clear_initial");

    // Write then read the same address on the next cycle.
    do_write(11'h005, 32'hDEADBEEF, 4'hF, "wr5", lat);
    chk("wr5_latency", lat, 1);
    do_read(11'h005, 32'hDEADBEEF, 1, "rd5", lat);
    chk("rd5_latency", lat, 1);
    @(negedge clk);
    chk("idle_hold", {bram_ena, bram_wea, bram_addra, bram_dina}, {1'b0, 4'h0, 11'h005, 32'h0});

    // Byte enables, back-to-back writes, and a zero-strobe write.
    do_write(11'h010, 32'hAABBCCDD, 4'hF, "wr10_full", lat);
    do_write(11'h010, 32'h12345678, 4'b0011, "wr10_low", lat);
    chk("wr_back2back_latency", lat, 2);
    do_write(11'h010, 32'hFFFFFFFF, 4'h0, "wr10_strb0", lat);
    do_read(11'h010, 32'hAABB5678, 1, "rd10", lat);

    // Both requesters held: W,R,W,R with the port busy every cycle.
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 11'h020; wr_data = 32'h11111111; wr_strb = 4'hF;
    rd_req = 1'b1; rd_addr = 11'h005;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("full_bw_ena", bram_ena, 1);
      chk("full_bw_acks", {wr_ack, rd_ack}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i % 2 == 1) exp_q.push_back(32'hDEADBEEF);
    end
    wr_req = 1'b0; rd_req = 1'b0;

    // Soft clear one cycle after a read grant, with a write held across the clear.
    @(negedge clk);
    do_read(11'h010, 32'hAABB5678, 1, "rd_before_clr", lat);
    @(negedge clk);
    clr_start = 1'b1;
    wr_req = 1'b1; wr_addr = 11'h030; wr_data = 32'hCAFEF00D; wr_strb = 4'hF;
    @(negedge clk);
    clr_start = 1'b0;
    chk("clr_busy_rise", init_busy, 1);
    chk("clr_gap_port", {wr_ack, rd_ack, bram_ena}, 0);
    do_clear(1, "clear_soft");
    chk("held_wr_after_clear", {wr_ack, bram_ena, bram_wea, bram_addra, bram_dina},
        {1'b1, 1'b1, 4'hF, 11'h030, 32'hCAFEF00D});
    wr_req = 1'b0;
    do_read(11'h030, 32'hCAFEF00D, 1, "rd30", lat);
    do_read(11'h010, CLR_V, 1, "rd10_cleared", lat);

    // Reset one cycle after a read grant; last grant before reset is a write.
    @(negedge clk);
    do_read(11'h005, 32'h0, 0, "rd_before_reset", lat);
    wr_req = 1'b1; wr_addr = 11'h040; wr_data = 32'h55AA55AA; wr_strb = 4'hF;
    @(negedge clk);
    chk("wr_before_reset_ack", wr_ack, 1);
    wr_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_kills_rd_valid", rd_valid, 0);
    chk("reset2_port", {bram_ena, bram_wea, bram_addra, bram_dina, wr_ack, rd_ack}, 0);
    chk("reset2_busy", init_busy, 1);
    reset = 1'b0;
    do_clear(1, "clear_after_reset");

    // First tie after reset goes to the writer.
    wr_req = 1'b1; wr_addr = 11'h041; wr_data = 32'h01020304; wr_strb = 4'hF;
    rd_req = 1'b1; rd_addr = 11'h041;
    @(negedge clk);
    chk("rr_reset_write_first", {wr_ack, rd_ack}, 2'b10);
    wr_req = 1'b0;
    exp_q.push_back(32'h01020304);
    @(negedge clk);
    chk("rr_then_read", {wr_ack, rd_ack}, 2'b01);
    rd_req = 1'b0;

    repeat (6) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
